avs_accel_csr: RTL and testbench
================================

# avs_accel_csr

Parametrised Avalon-MM slave control/status block for multi-channel accelerators. It holds a per-channel start/busy/done handshake, sticky done and error flags, a maskable interrupt, and a bank of byte-enabled user registers exported to the datapath. It sits between the Avalon interconnect and one or more accelerator cores. It replaces the fixed four-register slave with level-style start.

## Interface
- DATA_WIDTH, 32, bus width in bits; must be at least 32 and a multiple of 8.
- ADDRESS_WIDTH, 4, word address width; requires 2+NUM_REGS ≤ 2^ADDRESS_WIDTH.
- NUM_CHANNELS, 2, number of accelerator channels, 1..8.
- NUM_REGS, 4, number of user R/W registers, at least 1.
- CSI_CLOCK_CLK  in  1  single clock; all logic rising-edge.
- CSI_CLOCK_RESET  in  1  asynchronous, active-high reset.
- AVS_AVALONSLAVE_ADDRESS  in  ADDRESS_WIDTH  word address.
- AVS_AVALONSLAVE_READ  in  1  read request.
- AVS_AVALONSLAVE_WRITE  in  1  write request.
- AVS_AVALONSLAVE_BYTEENABLE  in  DATA_WIDTH/8  per-byte write enable.
- AVS_AVALONSLAVE_WRITEDATA  in  DATA_WIDTH  write data.
- AVS_AVALONSLAVE_READDATA  out  DATA_WIDTH  registered read data.
- AVS_AVALONSLAVE_WAITREQUEST  out  1  stall indication.
- START  out  NUM_CHANNELS  one-cycle start pulse per channel.
- DONE  in  NUM_CHANNELS  one-cycle completion pulse per channel.
- IRQ  out  1  level interrupt.
- USER_REGS  out  NUM_REGS*DATA_WIDTH  flat user registers; reg k is at bits [k*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Register map (word addresses):
  - 0 CTRL:
    - bits[C-1:0] start: write-1 requests a start; always read 0.
    - bits[16+C-1:16] irq_en: R/W.
  - 1 STATUS:
    - bits[C-1:0] busy: read-only.
    - bits[8+C-1:8] err: write-1-to-clear.
    - bits[16+C-1:16] done: write-1-to-clear.
  - 2..2+NUM_REGS-1 USER[k]: R/W.
  - All other addresses read 0; writes to them are ignored.
  - Unused bits read 0.
- Byte enables gate every write, including CTRL start bits and STATUS W1C bits. A bit is affected only if its byte lane is enabled.
- Per-channel state machine, states IDLE and BUSY:
  - IDLE: a start write drives START[c]=1 for exactly the next cycle, moves to BUSY, and sets busy[c].
  - BUSY: DONE[c] returns to IDLE, clears busy[c] and sets done[c].
  - A start write while BUSY emits no START pulse, leaves state unchanged and sets err[c].
  - DONE[c] while IDLE sets done[c] only.
- Simultaneous events:
  - DONE[c] together with a W1C of done[c]: set wins, done stays 1.
  - Start-error together with a W1C of err[c]: set wins.
  - DONE[c] in BUSY together with a start write for the same channel: channel returns to IDLE and the start is treated as issued from BUSY (err set, no pulse).
- IRQ = OR over c of (done[c] AND irq_en[c]), registered.
- Read and write asserted in the same cycle is illegal and undefined. The bench must never drive it.

## Timing
- Reset, asynchronous:
  - All registers, irq_en, done and err go to 0; all channels go to IDLE.
  - START=0, IRQ=0, READDATA=0, WAITREQUEST=0, USER_REGS=0.
  - Reset asserted mid-operation aborts any busy channel with no pulse or status.
- Write: zero wait states. WAITREQUEST stays 0 and the register updates at the capturing edge. A START pulse appears in the cycle after that edge.
- Read: fixed two-cycle access.
  - Cycle N (READ=1, first cycle): WAITREQUEST=1 combinationally; data is sampled into READDATA at the end of cycle N.
  - Cycle N+1: WAITREQUEST=0 and READDATA is valid.
  - An internal ack flag set at the end of N and cleared at the end of N+1 enables back-to-back reads, each taking 2 cycles.
- READDATA holds its last value when not reading.
- A read of STATUS returns the value before any same-cycle DONE update. Visibility of DONE is 1 cycle after the pulse.
- IRQ rises 1 cycle after done[c] sets while enabled. It falls 1 cycle after the W1C or after irq_en is cleared.

## Test plan
- Reset then read all map addresses -> each returns 0 with WAITREQUEST high for exactly 1 cycle per read; address 15 reads 0.
- Write 0xA5A5_5A5A to USER[1] with BYTEENABLE=0b0101 over a prior value of 0 -> readback 0x00A5_005A; USER_REGS bits [63:32] match.
- Write CTRL=0x0001_0001 -> START[0] high for exactly 1 cycle, busy[0]=1. Pulse DONE[0] -> STATUS reads 0x0001_0000 and IRQ=1 one cycle later. W1C 0x0001_0000 to STATUS -> IRQ=0.
- While channel 1 is busy, write CTRL bit 1 -> no START[1] pulse, STATUS bit 9 (err[1]) set. Write 0x200 to STATUS -> err cleared.
- Pulse DONE[0] in the same cycle as a W1C of done[0] -> done[0] remains 1.
- Assert reset while channel 0 is BUSY, then release -> STATUS=0, IRQ=0. A following start issues a normal pulse.

Source files
------------

// File: rtl/avs_accel_csr_if.sv
// Avalon-MM slave bus bundle for the accelerator CSR block.
// The host/interconnect side drives the master modport; the CSR block uses the slave modport.
interface avs_accel_csr_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 4
);
   logic [ADDRESS_WIDTH-1:0]  AVS_AVALONSLAVE_ADDRESS;
   logic                      AVS_AVALONSLAVE_READ;
   logic                      AVS_AVALONSLAVE_WRITE;
   logic [DATA_WIDTH/8-1:0]   AVS_AVALONSLAVE_BYTEENABLE;
   logic [DATA_WIDTH-1:0]     AVS_AVALONSLAVE_WRITEDATA;
   logic [DATA_WIDTH-1:0]     AVS_AVALONSLAVE_READDATA;
   logic                      AVS_AVALONSLAVE_WAITREQUEST;

   modport master (
      output AVS_AVALONSLAVE_ADDRESS,
      output AVS_AVALONSLAVE_READ,
      output AVS_AVALONSLAVE_WRITE,
      output AVS_AVALONSLAVE_BYTEENABLE,
      output AVS_AVALONSLAVE_WRITEDATA,
      input  AVS_AVALONSLAVE_READDATA,
      input  AVS_AVALONSLAVE_WAITREQUEST
   );

   modport slave (
      input  AVS_AVALONSLAVE_ADDRESS,
      input  AVS_AVALONSLAVE_READ,
      input  AVS_AVALONSLAVE_WRITE,
      input  AVS_AVALONSLAVE_BYTEENABLE,
      input  AVS_AVALONSLAVE_WRITEDATA,
      output AVS_AVALONSLAVE_READDATA,
      output AVS_AVALONSLAVE_WAITREQUEST
   );
endinterface

// File: rtl/avs_accel_csr.sv
// Avalon-MM control/status slave for multi-channel accelerators: per-channel start/busy/done
// handshake, sticky done/err flags, maskable level IRQ and byte-enabled user registers.
module avs_accel_csr #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 4,
   parameter int NUM_CHANNELS  = 2,
   parameter int NUM_REGS      = 4
) (
   input  logic                           CSI_CLOCK_CLK,
   input  logic                           CSI_CLOCK_RESET,
   avs_accel_csr_if.slave                 avs,
   output logic [NUM_CHANNELS-1:0]        START,
   input  logic [NUM_CHANNELS-1:0]        DONE,
   output logic                           IRQ,
   output logic [NUM_REGS*DATA_WIDTH-1:0] USER_REGS
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;

   typedef enum logic {
      IDLE,
      BUSY
   } chan_state_t;

   chan_state_t               state [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]   busy;
   logic [NUM_CHANNELS-1:0]   irq_en;
   logic [NUM_CHANNELS-1:0]   done_flag;
   logic [NUM_CHANNELS-1:0]   err_flag;
   logic [NUM_CHANNELS-1:0]   start_req;
   logic [NUM_CHANNELS-1:0]   err_clr;
   logic [NUM_CHANNELS-1:0]   done_clr;
   logic [DATA_WIDTH-1:0]     user_reg [NUM_REGS];
   logic [DATA_WIDTH-1:0]     rd_mux;
   logic                      ack;

   logic [ADDRESS_WIDTH-1:0]  address;
   logic                      read;
   logic                      write;
   logic [NUM_BYTES-1:0]      byteenable;
   logic [DATA_WIDTH-1:0]     writedata;
   logic                      wr_ctrl;
   logic                      wr_status;

   assign address    = avs.AVS_AVALONSLAVE_ADDRESS;
   assign read       = avs.AVS_AVALONSLAVE_READ;
   assign write      = avs.AVS_AVALONSLAVE_WRITE;
   assign byteenable = avs.AVS_AVALONSLAVE_BYTEENABLE;
   assign writedata  = avs.AVS_AVALONSLAVE_WRITEDATA;

   assign wr_ctrl   = write && (address == ADDRESS_WIDTH'(0));
   assign wr_status = write && (address == ADDRESS_WIDTH'(1));

   // Channel fields never exceed 8 bits, so each field lives entirely in one byte lane.
   assign start_req = (wr_ctrl   && byteenable[0]) ? writedata[NUM_CHANNELS-1:0]     : '0;
   assign err_clr   = (wr_status && byteenable[1]) ? writedata[8 +: NUM_CHANNELS]    : '0;
   assign done_clr  = (wr_status && byteenable[2]) ? writedata[16 +: NUM_CHANNELS]   : '0;

   always_comb begin
      busy = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         busy[c] = (state[c] == BUSY);
      end
   end

   // Per-channel handshake FSM; START is a registered one-cycle pulse.
   always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
      if (CSI_CLOCK_RESET) begin
         START <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state[c] <= IDLE;
         end
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            START[c] <= 1'b0;
            case (state[c])
               IDLE: begin
                  if (start_req[c]) begin
                     START[c] <= 1'b1;
                     state[c] <= BUSY;
                  end
               end
               BUSY: begin
                  if (DONE[c]) begin
                     state[c] <= IDLE;
                  end
               end
               default: state[c] <= IDLE;
            endcase
         end
      end
   end

   // Sticky flags: a same-cycle set always beats the write-1-to-clear.
   always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
      if (CSI_CLOCK_RESET) begin
         err_flag  <= '0;
         done_flag <= '0;
         irq_en    <= '0;
         IRQ       <= 1'b0;
      end else begin
         err_flag  <= (err_flag & ~err_clr) | (start_req & busy);
         done_flag <= (done_flag & ~done_clr) | DONE;
         if (wr_ctrl && byteenable[2]) begin
            irq_en <= writedata[16 +: NUM_CHANNELS];
         end
         IRQ <= |(done_flag & irq_en);
      end
   end

   always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
      if (CSI_CLOCK_RESET) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            user_reg[k] <= '0;
         end
      end else if (write) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (address == ADDRESS_WIDTH'(k + 2)) begin
               for (int b = 0; b < NUM_BYTES; b++) begin
                  if (byteenable[b]) begin
                     user_reg[k][b*8 +: 8] <= writedata[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_user_out
         assign USER_REGS[g*DATA_WIDTH +: DATA_WIDTH] = user_reg[g];
      end
   endgenerate

   always_comb begin
      rd_mux = '0;
      if (address == ADDRESS_WIDTH'(0)) begin
         rd_mux[16 +: NUM_CHANNELS] = irq_en;
      end else if (address == ADDRESS_WIDTH'(1)) begin
         rd_mux[NUM_CHANNELS-1:0]   = busy;
         rd_mux[8 +: NUM_CHANNELS]  = err_flag;
         rd_mux[16 +: NUM_CHANNELS] = done_flag;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (address == ADDRESS_WIDTH'(k + 2)) begin
               rd_mux = user_reg[k];
            end
         end
      end
   end

   // Two-cycle read: the first cycle stalls and captures, the ack cycle completes it.
   assign avs.AVS_AVALONSLAVE_WAITREQUEST = read & ~ack;

   always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
      if (CSI_CLOCK_RESET) begin
         ack                          <= 1'b0;
         avs.AVS_AVALONSLAVE_READDATA <= '0;
      end else begin
         ack <= read & ~ack;
         if (read && !ack) begin
            avs.AVS_AVALONSLAVE_READDATA <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_avs_accel_csr.sv
// Directed plus randomized bench for avs_accel_csr, checked against a flag-level reference model.
module tb_avs_accel_csr;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NC = 2;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   avs_accel_csr_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   logic [NC-1:0]    start;
   logic [NC-1:0]    done_in;
   logic             irq;
   logic [NR*DW-1:0] user_regs;

   avs_accel_csr #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CHANNELS(NC), .NUM_REGS(NR)
   ) dut (
      .CSI_CLOCK_CLK   (clk),
      .CSI_CLOCK_RESET (rst),
      .avs             (bus.slave),
      .START           (start),
      .DONE            (done_in),
      .IRQ             (irq),
      .USER_REGS       (user_regs)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [NC-1:0] m_busy, m_irq_en, m_done, m_err;
   logic [DW-1:0] m_user [NR];

   task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = '0; m_irq_en = '0; m_done = '0; m_err = '0;
      for (int k = 0; k < NR; k++) m_user[k] = '0;
   endtask

   function automatic logic m_irq();
      return |(m_done & m_irq_en);
   endfunction

   function automatic logic [NR*DW-1:0] m_flat();
      logic [NR*DW-1:0] f;
      for (int k = 0; k < NR; k++) f[k*DW +: DW] = m_user[k];
      return f;
   endfunction

   function automatic logic [DW-1:0] model_read(input int a);
      logic [DW-1:0] r;
      r = '0;
      if (a == 0) begin
         r[16 +: NC] = m_irq_en;
      end else if (a == 1) begin
         r[NC-1:0] = m_busy;
         r[8 +: NC] = m_err;
         r[16 +: NC] = m_done;
      end else if (a >= 2 && a < 2 + NR) begin
         r = m_user[a-2];
      end
      return r;
   endfunction

   task automatic model_write(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] be,
                              input logic [NC-1:0] dm, output logic [NC-1:0] pulse);
      logic [NC-1:0] sr, ce, cd;
      sr = (a == 0 && be[0]) ? d[NC-1:0] : '0;
      ce = (a == 1 && be[1]) ? d[8 +: NC] : '0;
      cd = (a == 1 && be[2]) ? d[16 +: NC] : '0;
      pulse  = sr & ~m_busy;
      m_err  = (m_err & ~ce) | (sr & m_busy);
      m_done = (m_done & ~cd) | dm;
      m_busy = (m_busy & ~dm) | pulse;
      if (a == 0 && be[2]) m_irq_en = d[16 +: NC];
      if (a >= 2 && a < 2 + NR) begin
         for (int b = 0; b < DW/8; b++) begin
            if (be[b]) m_user[a-2][b*8 +: 8] = d[b*8 +: 8];
         end
      end
   endtask

   task automatic do_write(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] be,
                           input logic [NC-1:0] dm);
      logic [NC-1:0] exp_pulse;
      @(negedge clk);
      bus.AVS_AVALONSLAVE_ADDRESS    = AW'(a);
      bus.AVS_AVALONSLAVE_WRITEDATA  = d;
      bus.AVS_AVALONSLAVE_BYTEENABLE = be;
      bus.AVS_AVALONSLAVE_WRITE      = 1'b1;
      done_in = dm;
      #1 check("wr_waitrequest", bus.AVS_AVALONSLAVE_WAITREQUEST, 1'b0);
      model_write(a, d, be, dm, exp_pulse);
      @(negedge clk);
      bus.AVS_AVALONSLAVE_WRITE = 1'b0;
      done_in = '0;
      check("start_pulse", start, exp_pulse);
      @(negedge clk);
      check("start_after", start, '0);
      check("irq_after_wr", irq, m_irq());
   endtask

   task automatic do_read(input int a);
      logic [DW-1:0] exp;
      int n;
      exp = model_read(a);
      n = 0;
      @(negedge clk);
      bus.AVS_AVALONSLAVE_ADDRESS = AW'(a);
      bus.AVS_AVALONSLAVE_READ    = 1'b1;
      #1;
      while (bus.AVS_AVALONSLAVE_WAITREQUEST === 1'b1 && n < 8) begin
         @(posedge clk);
         #1 n++;
      end
      check("rd_wait_cycles", n, 1);
      check($sformatf("rd_data_a%0d", a), bus.AVS_AVALONSLAVE_READDATA, exp);
      @(posedge clk);
      #1 bus.AVS_AVALONSLAVE_READ = 1'b0;
   endtask

   task automatic pulse_done(input logic [NC-1:0] mask);
      logic old_irq;
      logic [NC-1:0] unused_pulse;
      old_irq = m_irq();
      @(negedge clk);
      done_in = mask;
      model_write(15, '0, '0, mask, unused_pulse);
      @(negedge clk);
      done_in = '0;
      check("irq_lag", irq, old_irq);
      @(negedge clk);
      check("irq_after_done", irq, m_irq());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] held;
      bus.AVS_AVALONSLAVE_ADDRESS    = '0;
      bus.AVS_AVALONSLAVE_READ       = 1'b0;
      bus.AVS_AVALONSLAVE_WRITE      = 1'b0;
      bus.AVS_AVALONSLAVE_BYTEENABLE = '0;
      bus.AVS_AVALONSLAVE_WRITEDATA  = '0;
      done_in = '0;
      model_reset();

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_start", start, '0);
      check("rst_irq", irq, 1'b0);
      check("rst_readdata", bus.AVS_AVALONSLAVE_READDATA, '0);
      check("rst_waitrequest", bus.AVS_AVALONSLAVE_WAITREQUEST, 1'b0);
      check("rst_user_regs", user_regs, '0);
      rst = 1'b0;

      for (int a = 0; a < 16; a++) do_read(a);

      // Byte-enabled user write
      do_write(3, 32'hA5A5_5A5A, 4'b0101, '0);
      do_read(3);
      check("user1_export", user_regs[63:32], 32'h00A5_005A);
      held = bus.AVS_AVALONSLAVE_READDATA;
      repeat (2) @(negedge clk);
      check("readdata_hold", bus.AVS_AVALONSLAVE_READDATA, held);

      // Start / done / irq on channel 0
      do_write(0, 32'h0001_0001, 4'hF, '0);
      do_read(1);
      pulse_done(2'b01);
      do_read(1);
      check("irq_done0", irq, 1'b1);
      do_write(1, 32'h0001_0000, 4'hF, '0);
      check("irq_cleared", irq, 1'b0);

      // Start while busy on channel 1
      do_write(0, 32'h0001_0002, 4'hF, '0);
      do_write(0, 32'h0001_0002, 4'hF, '0);
      do_read(1);
      do_write(1, 32'h0000_0200, 4'hF, '0);
      do_read(1);
      pulse_done(2'b10);

      // Start bit with its byte lane disabled
      do_write(0, 32'h0001_0001, 4'b1110, '0);
      do_read(1);

      // Done set beats W1C; W1C with lane disabled has no effect
      do_write(1, 32'h0001_0000, 4'hF, 2'b01);
      do_read(1);
      do_write(1, 32'h0001_0000, 4'b1011, '0);
      do_read(1);
      do_write(1, 32'h0001_0000, 4'hF, '0);

      // Reset in the middle of a busy channel
      do_write(0, 32'h0003_0001, 4'hF, '0);
      pulse_done(2'b10);
      check("irq_before_rst", irq, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_start", start, '0);
      check("mid_rst_irq", irq, 1'b0);
      check("mid_rst_user", user_regs, '0);
      check("mid_rst_readdata", bus.AVS_AVALONSLAVE_READDATA, '0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      do_read(1);
      check("post_rst_irq", irq, 1'b0);
      do_write(0, 32'h0000_0001, 4'hF, '0);
      do_read(1);
      pulse_done(2'b01);

      // Randomized traffic
      for (int i = 0; i < 200; i++) begin
         int op;
         op = $urandom_range(0, 3);
         case (op)
            0: do_write($urandom_range(0, 15), $urandom, 4'($urandom), NC'($urandom));
            1: do_read($urandom_range(0, 15));
            2: pulse_done(NC'($urandom));
            default: do_write(0, {15'd0, 1'b0, 14'd0, 2'($urandom)} | 32'($urandom_range(0, 3)) << 16,
                              4'($urandom) | 4'b0001, '0);
         endcase
      end
      check("final_user_regs", user_regs, m_flat());
      for (int a = 0; a < 2 + NR; a++) do_read(a);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
